// File: rtl/sbox_share_ctrl.sv
// -----------------------------------------------------------------------------
// sbox_share_ctrl
//
// Shares four AES forward S-box lanes between two clients:
//   * a 128-bit state SubBytes operation, substituted 32 bits (one "beat")
//     per cycle over four beats, and
//   * single-word SubWord requests from the key schedule.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst_n      : synchronous active-low reset
//   st_valid   : state offered for SubBytes
//   st_data    : 128-bit state, byte i = bits [8i+7:8i]
//   st_ready   : state accepted this cycle (IDLE only, never in reset)
//   res_valid  : res_data holds a completed SubBytes result
//   res_data   : substituted state, stable while res_valid is high
//   res_ready  : downstream consumes the result
//   kw_req     : key-word request, held high until kw_ack
//   kw_data    : word to substitute, stable while kw_req is high
//   kw_ack     : one-cycle pulse, kw_result valid
//   kw_result  : substituted key word, held until the next ack
//
// Parameter
//   KEY_PRIO   : 1 = key-word request takes the lanes during SubBytes,
//                0 = SubBytes keeps the lanes until it completes
// -----------------------------------------------------------------------------
module sbox_share_ctrl #(
  parameter int KEY_PRIO = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  input  logic [127:0] st_data,
  output logic         st_ready,
  output logic         res_valid,
  output logic [127:0] res_data,
  input  logic         res_ready,
  input  logic         kw_req,
  input  logic [31:0]  kw_data,
  output logic         kw_ack,
  output logic [31:0]  kw_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] SBOX_TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  res_q, res_d;
  logic          res_valid_q, res_valid_d;
  logic          kw_ack_q, kw_ack_d;
  logic [31:0]   kw_res_q, kw_res_d;

  logic          key_grant;
  logic          beat_go;
  logic [31:0]   lane_in;
  logic [31:0]   lane_out;

  // The key word may take the lanes whenever SubBytes is not running; during
  // SubBytes only when it has priority. Blocking grant in the ack cycle
  // guarantees a state beat at least every other cycle.
  assign key_grant = kw_req && !kw_ack_q &&
                     ((state_q != SUB) || (KEY_PRIO != 0));
  assign beat_go   = (state_q == SUB) && !key_grant;

  // Four shared lanes: the key word when granted, otherwise the current beat.
  assign lane_in = key_grant ? kw_data : st_q[{beat_q, 5'd0} +: 32];

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign lane_out[8*g +: 8] = sbox(lane_in[8*g +: 8]);
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    st_d        = st_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    kw_ack_d    = key_grant;
    kw_res_d    = kw_res_q;

    if (key_grant) begin
      kw_res_d = lane_out;
    end

    case (state_q)
      IDLE: begin
        // Capture uses no lanes, so a key grant may happen in the same cycle.
        if (st_valid) begin
          state_d = SUB;
          beat_d  = 2'd0;
          st_d    = st_data;
        end
      end
      SUB: begin
        if (beat_go) begin
          res_d[{beat_q, 5'd0} +: 32] = lane_out;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d     = HOLD;
            res_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      kw_ack_q    <= 1'b0;
      kw_res_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      kw_ack_q    <= kw_ack_d;
      kw_res_q    <= kw_res_d;
    end
    // Captured input state is pure data; it is only read after a capture.
    st_q <= st_d;
  end

  assign st_ready  = (state_q == IDLE) && rst_n;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign kw_ack    = kw_ack_q;
  assign kw_result = kw_res_q;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
`timescale 1ns/1ps
module tb_sbox_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         st_valid  [2];
  logic [127:0] st_data   [2];
  logic         res_ready [2];
  logic         kw_req    [2];
  logic [31:0]  kw_data   [2];
  logic         st_ready  [2];
  logic         res_valid [2];
  logic [127:0] res_data  [2];
  logic         kw_ack    [2];
  logic [31:0]  kw_result [2];

  // Instance 0: key priority; instance 1: state priority.
  sbox_share_ctrl #(.KEY_PRIO(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid[0]), .st_data(st_data[0]), .st_ready(st_ready[0]),
    .res_valid(res_valid[0]), .res_data(res_data[0]), .res_ready(res_ready[0]),
    .kw_req(kw_req[0]), .kw_data(kw_data[0]), .kw_ack(kw_ack[0]), .kw_result(kw_result[0])
  );

  sbox_share_ctrl #(.KEY_PRIO(0)) dut_p0 (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid[1]), .st_data(st_data[1]), .st_ready(st_ready[1]),
    .res_valid(res_valid[1]), .res_data(res_data[1]), .res_ready(res_ready[1]),
    .kw_req(kw_req[1]), .kw_data(kw_data[1]), .kw_ack(kw_ack[1]), .kw_result(kw_result[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference S-box from GF(2^8) arithmetic ----------------
  logic [7:0] ref_sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_sbox[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sbox[s[8*i +: 8]];
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] st;
    logic [31:0]  kw;
    logic [127:0] st_exp;
    logic [31:0]  kw_exp;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  // ---------------- random-phase model state ----------------
  int           m_left [2];   // beats still to substitute
  bit           m_have [2];   // completed result waiting for consumer
  bit           m_ack  [2];
  logic [127:0] m_cap  [2];
  logic [127:0] m_res  [2];
  logic [127:0] m_exp  [2];
  logic [31:0]  m_kres [2];
  int           prio   [2];

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      st_valid[d] = 1'b0; st_data[d] = '0; res_ready[d] = 1'b0;
      kw_req[d] = 1'b0; kw_data[d] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) chk($sformatf("rst%0d_st_ready_low", d), st_ready[d], 1'b0);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic consume(input int d);
    res_ready[d] = 1'b1;
    tick();
    res_ready[d] = 1'b0;
    chk($sformatf("d%0d_after_consume_res_valid", d), res_valid[d], 1'b0);
    chk($sformatf("d%0d_after_consume_st_ready", d), st_ready[d], 1'b1);
  endtask

  task automatic model_step(input int d);
    bit idle, sub, grant;
    int idx;
    if (!rst_n) begin
      m_left[d] = 0; m_have[d] = 0; m_ack[d] = 0;
      m_res[d] = '0; m_kres[d] = '0;
    end else begin
      idle  = (m_left[d] == 0) && !m_have[d];
      sub   = (m_left[d] != 0);
      grant = kw_req[d] && !m_ack[d] && (!sub || prio[d] != 0);
      if (grant) m_kres[d] = sub32(kw_data[d]);
      if (sub && !grant) begin
        idx = 4 - m_left[d];
        m_res[d][32*idx +: 32] = sub32(m_cap[d][32*idx +: 32]);
        m_left[d]--;
        if (m_left[d] == 0) m_have[d] = 1;
      end else if (m_have[d] && res_ready[d]) begin
        chk($sformatf("rnd%0d_consumed_data", d), res_data[d], m_exp[d]);
        m_have[d] = 0;
      end
      if (idle && st_valid[d]) begin
        m_left[d] = 4;
        m_cap[d]  = st_data[d];
        m_exp[d]  = sub128(st_data[d]);
      end
      m_ack[d] = grant;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    prio[0] = 1; prio[1] = 0;
    for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_math(8'(i));

    vecs[0] = '{128'h00112233445566778899AABBCCDDEEFF, 32'hCF4F3C09,
                128'h638293C31BFC33F5C4EEACEA4BC12816, 32'h8A84EB01};
    vecs[1] = '{128'h0, 32'h00000000, {16{8'h63}}, 32'h63636363};
    vecs[2] = '{{16{8'h53}}, 32'h01010101, {16{8'hed}}, 32'h7c7c7c7c};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 32'hffeeddcc,
                128'h637c777bf26b6fc53001672bfed7ab76, 32'h1628c14b};
    vecs[4] = '{{16{8'hff}}, 32'h10203040, {16{8'h16}}, 32'hcab70409};

    // Reset state
    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_st_ready", d), st_ready[d], 1'b1);
      chk($sformatf("rst%0d_res_valid", d), res_valid[d], 1'b0);
      chk($sformatf("rst%0d_kw_ack", d), kw_ack[d], 1'b0);
      chk($sformatf("rst%0d_res_data", d), res_data[d], 128'h0);
      chk($sformatf("rst%0d_kw_result", d), kw_result[d], 32'h0);
    end

    // Table: state and key word offered together in IDLE
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < NV; v++) begin
        st_valid[d] = 1'b1; st_data[d] = vecs[v].st;
        kw_req[d] = 1'b1; kw_data[d] = vecs[v].kw;
        chk($sformatf("v%0d_d%0d_st_ready", v, d), st_ready[d], 1'b1);
        tick();                                   // cycle T+1
        st_valid[d] = 1'b0;
        chk($sformatf("v%0d_d%0d_kw_ack", v, d), kw_ack[d], 1'b1);
        chk($sformatf("v%0d_d%0d_kw_result", v, d), kw_result[d], vecs[v].kw_exp);
        kw_req[d] = 1'b0;
        chk($sformatf("v%0d_d%0d_res_valid_T1", v, d), res_valid[d], 1'b0);
        tick();                                   // T+2
        chk($sformatf("v%0d_d%0d_kw_ack_T2", v, d), kw_ack[d], 1'b0);
        tick(); tick();                           // T+4
        chk($sformatf("v%0d_d%0d_res_valid_T4", v, d), res_valid[d], 1'b0);
        tick();                                   // T+5
        chk($sformatf("v%0d_d%0d_res_valid_T5", v, d), res_valid[d], 1'b1);
        chk($sformatf("v%0d_d%0d_res_data", v, d), res_data[d], vecs[v].st_exp);
        chk($sformatf("v%0d_d%0d_kw_result_held", v, d), kw_result[d], vecs[v].kw_exp);
        consume(d);
      end
    end

    // Key request at T+2 with key priority: one-cycle stall
    st_valid[0] = 1'b1; st_data[0] = vecs[0].st;
    tick(); st_valid[0] = 1'b0;                   // T+1
    tick();                                       // T+2
    kw_req[0] = 1'b1; kw_data[0] = 32'hCF4F3C09;
    tick();                                       // T+3
    chk("kp1_kw_ack_T3", kw_ack[0], 1'b1);
    chk("kp1_kw_result_T3", kw_result[0], 32'h8A84EB01);
    kw_req[0] = 1'b0;
    tick(); tick();                               // T+5
    chk("kp1_res_valid_T5", res_valid[0], 1'b0);
    tick();                                       // T+6
    chk("kp1_res_valid_T6", res_valid[0], 1'b1);
    chk("kp1_res_data", res_data[0], vecs[0].st_exp);
    consume(0);

    // Same stimulus with state priority: key waits for HOLD
    st_valid[1] = 1'b1; st_data[1] = vecs[0].st;
    tick(); st_valid[1] = 1'b0;                   // T+1
    tick();                                       // T+2
    kw_req[1] = 1'b1; kw_data[1] = 32'hCF4F3C09;
    tick();                                       // T+3
    chk("kp0_kw_ack_T3", kw_ack[1], 1'b0);
    tick();                                       // T+4
    chk("kp0_kw_ack_T4", kw_ack[1], 1'b0);
    tick();                                       // T+5
    chk("kp0_res_valid_T5", res_valid[1], 1'b1);
    chk("kp0_kw_ack_T5", kw_ack[1], 1'b0);
    chk("kp0_res_data", res_data[1], vecs[0].st_exp);
    tick();                                       // T+6
    chk("kp0_kw_ack_T6", kw_ack[1], 1'b1);
    chk("kp0_kw_result_T6", kw_result[1], 32'h8A84EB01);
    kw_req[1] = 1'b0;
    consume(1);

    // Backpressure: result held for 10 cycles, no accept in the release cycle
    st_valid[0] = 1'b1; st_data[0] = vecs[3].st;
    tick(); st_valid[0] = 1'b0;
    tick(); tick(); tick(); tick();               // T+5
    st_valid[0] = 1'b1; st_data[0] = vecs[1].st;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp%0d_res_valid", k), res_valid[0], 1'b1);
      chk($sformatf("bp%0d_res_data", k), res_data[0], vecs[3].st_exp);
      chk($sformatf("bp%0d_st_ready", k), st_ready[0], 1'b0);
      tick();
    end
    res_ready[0] = 1'b1;
    chk("bp_release_st_ready", st_ready[0], 1'b0);
    tick();
    res_ready[0] = 1'b0;
    chk("bp_idle_res_valid", res_valid[0], 1'b0);
    chk("bp_idle_st_ready", st_ready[0], 1'b1);
    st_valid[0] = 1'b0;
    tick();

    // Continuous key requests with key priority: SUB still completes
    st_valid[0] = 1'b1; st_data[0] = vecs[2].st;
    kw_req[0] = 1'b1; kw_data[0] = 32'h10203040;
    tick(); st_valid[0] = 1'b0;                   // T+1
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("cont_T%0d_kw_ack", k), kw_ack[0], (k % 2) == 1);
      chk($sformatf("cont_T%0d_res_valid", k), res_valid[0], 1'b0);
      tick();
    end
    kw_req[0] = 1'b0;                             // T+8
    chk("cont_T8_res_valid", res_valid[0], 1'b1);
    chk("cont_T8_res_data", res_data[0], vecs[2].st_exp);
    chk("cont_kw_result", kw_result[0], 32'hcab70409);
    consume(0);

    // Reset in the middle of SUB with a key request pending
    st_valid[0] = 1'b1; st_data[0] = vecs[4].st;
    tick(); st_valid[0] = 1'b0;                   // T+1
    tick(); tick();                               // T+3
    rst_n = 1'b0; kw_req[0] = 1'b1; kw_data[0] = 32'h00000000;
    tick();
    rst_n = 1'b1; kw_req[0] = 1'b0;
    #1;
    chk("midrst_st_ready", st_ready[0], 1'b1);
    chk("midrst_res_valid", res_valid[0], 1'b0);
    chk("midrst_kw_ack", kw_ack[0], 1'b0);
    chk("midrst_res_data", res_data[0], 128'h0);
    chk("midrst_kw_result", kw_result[0], 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("midrst_noresult%0d", k), res_valid[0], 1'b0);
    end

    // Randomized traffic against the reference model
    idle_inputs();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_have[d] = 0; m_ack[d] = 0;
      m_res[d] = '0; m_kres[d] = '0; m_cap[d] = '0; m_exp[d] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int d = 0; d < 2; d++) begin
        st_valid[d]  = $urandom_range(0, 1) == 1;
        st_data[d]   = {$urandom, $urandom, $urandom, $urandom};
        res_ready[d] = ($urandom_range(0, 9) < 4);
        if (kw_req[d]) begin
          if (m_ack[d] && $urandom_range(0, 3) != 0) kw_req[d] = 1'b0;
        end else if ($urandom_range(0, 9) < 3) begin
          kw_req[d]  = 1'b1;
          kw_data[d] = $urandom;
        end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rnd%0d_st_ready", d), st_ready[d],
            rst_n && (m_left[d] == 0) && !m_have[d]);
        model_step(d);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rnd%0d_res_valid", d), res_valid[d], m_have[d]);
        chk($sformatf("rnd%0d_kw_ack", d), kw_ack[d], m_ack[d]);
        chk($sformatf("rnd%0d_res_data", d), res_data[d], m_res[d]);
        chk($sformatf("rnd%0d_kw_result", d), kw_result[d], m_kres[d]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
